// File: rtl/tree_sample_sequencer.sv
// Host-side sequencer for the decision-tree classifier: packs a streamed sample onto
// a parallel feature bus, clears and runs the tree, then returns label and correctness.
//
// state  | meaning
// LOAD   | accepting feature words into the feature bus
// DROP   | over-length sample, discarding words until in_last
// CLR    | one-cycle active-low clear to the classifier
// RUN    | traversal running, waiting for done or timeout
// RESULT | result held on the valid/ready port
module tree_sample_sequencer #(
    parameter int N_FEATURES = 11,
    parameter int FEAT_W     = 16,
    parameter int TREE_DEPTH = 3,
    parameter int TIMEOUT    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FEAT_W-1:0]            in_data,
    input  logic                         in_last,
    input  logic                         in_truth,
    input  logic                         clr_err,
    output logic [N_FEATURES*FEAT_W-1:0] feat_bus,
    output logic                         tree_rst_n,
    output logic                         tree_start,
    output logic [3:0]                   tree_depth,
    input  logic                         tree_done,
    input  logic                         tree_label,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         res_label,
    output logic                         res_correct,
    output logic                         err_len,
    output logic                         err_timeout,
    output logic [15:0]                  sample_count,
    output logic [15:0]                  correct_count
);

    localparam int IDX_W = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_LOAD   = 3'd0;
    localparam logic [2:0] ST_DROP   = 3'd1;
    localparam logic [2:0] ST_CLR    = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [FEAT_W-1:0] r_feat [N_FEATURES];
    logic             r_truth;
    logic [TMR_W-1:0] r_tmr;
    logic             r_tree_rst_n;
    logic             r_tree_start;
    logic             r_res_valid;
    logic             r_res_label;
    logic             r_res_correct;
    logic             r_err_len;
    logic             r_err_timeout;
    logic [15:0]      r_sample_cnt;
    logic [15:0]      r_correct_cnt;

    logic             w_accept;
    logic             w_idx_last;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_len_evt;
    logic             w_to_evt;
    logic             w_load_wr;

    assign in_ready   = (r_state == ST_LOAD) || (r_state == ST_DROP);
    assign w_accept   = in_valid & in_ready;
    assign w_idx_last = (r_idx == IDX_W'(N_FEATURES - 1));
    assign w_wr_idx   = IDX_W'(N_FEATURES - 1) - r_idx;
    assign w_load_wr  = (r_state == ST_LOAD) & w_accept;

    // Length error: in_last too early, or the final slot filled without in_last.
    assign w_len_evt  = w_load_wr & (in_last ? ~w_idx_last : w_idx_last);
    assign w_to_evt   = (r_state == ST_RUN) & ~tree_done & (r_tmr == '0);

    genvar g;
    generate
        for (g = 0; g < N_FEATURES; g++) begin : g_feat
            assign feat_bus[g*FEAT_W +: FEAT_W] = r_feat[g];
        end
    endgenerate

    assign tree_rst_n    = r_tree_rst_n;
    assign tree_start    = r_tree_start;
    assign tree_depth    = 4'(TREE_DEPTH);
    assign res_valid     = r_res_valid;
    assign res_label     = r_res_label;
    assign res_correct   = r_res_correct;
    assign err_len       = r_err_len;
    assign err_timeout   = r_err_timeout;
    assign sample_count  = r_sample_cnt;
    assign correct_count = r_correct_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_FEATURES; i++) begin
                r_feat[i] <= '0;
            end
        end else if (w_load_wr) begin
            r_feat[w_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            // A new error event in the same cycle as clr_err keeps the flag set.
            r_err_len     <= w_len_evt | (r_err_len & ~clr_err);
            r_err_timeout <= w_to_evt  | (r_err_timeout & ~clr_err);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_LOAD;
            r_idx         <= '0;
            r_truth       <= 1'b0;
            r_tmr         <= '0;
            r_tree_rst_n  <= 1'b0;
            r_tree_start  <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_label   <= 1'b0;
            r_res_correct <= 1'b0;
            r_sample_cnt  <= '0;
            r_correct_cnt <= '0;
        end else begin
            r_tree_rst_n <= 1'b1;
            r_tree_start <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (in_last) begin
                            r_idx <= '0;
                            if (w_idx_last) begin
                                r_truth      <= in_truth;
                                r_tree_rst_n <= 1'b0;
                                r_state      <= ST_CLR;
                            end
                        end else if (w_idx_last) begin
                            r_idx   <= '0;
                            r_state <= ST_DROP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_accept && in_last) begin
                        r_idx   <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_CLR: begin
                    r_tmr   <= TMR_W'(TIMEOUT - 1);
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (tree_done) begin
                        r_res_label   <= tree_label;
                        r_res_correct <= (tree_label == r_truth);
                        r_res_valid   <= 1'b1;
                        r_state       <= ST_RESULT;
                    end else if (r_tmr == '0) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_tree_start <= 1'b1;
                        r_tmr        <= r_tmr - 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_sample_cnt != 16'hFFFF) begin
                            r_sample_cnt <= r_sample_cnt + 16'd1;
                        end
                        if (r_res_correct && (r_correct_cnt != 16'hFFFF)) begin
                            r_correct_cnt <= r_correct_cnt + 16'd1;
                        end
                        r_state <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tree_sample_sequencer.sv
// Directed bench for tree_sample_sequencer with a behavioural depth-3 classifier model.
// Done is raised after 5 sampled start cycles unless the model is told to hang.
module tb_tree_sample_sequencer;

    localparam int NF = 11;
    localparam int FW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [FW-1:0]     in_data;
    logic              in_last;
    logic              in_truth;
    logic              clr_err;
    logic [NF*FW-1:0]  feat_bus;
    logic              tree_rst_n;
    logic              tree_start;
    logic [3:0]        tree_depth;
    logic              tree_done = 1'b0;
    logic              tree_label;
    logic              res_valid;
    logic              res_ready;
    logic              res_label;
    logic              res_correct;
    logic              err_len;
    logic              err_timeout;
    logic [15:0]       sample_count;
    logic [15:0]       correct_count;

    tree_sample_sequencer #(.N_FEATURES(NF), .FEAT_W(FW), .TREE_DEPTH(3), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_truth(in_truth), .clr_err(clr_err),
        .feat_bus(feat_bus), .tree_rst_n(tree_rst_n), .tree_start(tree_start),
        .tree_depth(tree_depth), .tree_done(tree_done), .tree_label(tree_label),
        .res_valid(res_valid), .res_ready(res_ready), .res_label(res_label),
        .res_correct(res_correct), .err_len(err_len), .err_timeout(err_timeout),
        .sample_count(sample_count), .correct_count(correct_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int rst_low_tot = 0;
    int start_tot = 0;
    int rv_tot = 0;
    logic rv_prev = 1'b0;
    int m_cnt = 0;
    logic m_hang = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!tree_rst_n) rst_low_tot <= rst_low_tot + 1;
        if (tree_start)  start_tot <= start_tot + 1;
        rv_prev <= res_valid;
        if (res_valid && !rv_prev) rv_tot <= rv_tot + 1;
    end

    always @(posedge clk) begin
        if (!tree_rst_n) begin
            m_cnt     <= 0;
            tree_done <= 1'b0;
        end else if (tree_start && !m_hang && !tree_done) begin
            if (m_cnt == 4) tree_done <= 1'b1;
            m_cnt <= m_cnt + 1;
        end
    end

    int tests = 0;
    int failed = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int nw, input int lastpos, input logic truth,
                        input logic [15:0] base, output int t_acc);
        int guard;
        for (int k = 0; k < nw; k++) begin
            in_valid = 1'b1;
            in_data  = base + 16'(k);
            in_last  = (k + 1 == lastpos);
            in_truth = truth;
            guard = 0;
            while (!in_ready && guard < 50) begin
                tick;
                guard++;
            end
            if (guard >= 50) chk("in_ready_wait", 0, 1);
            tick;
        end
        t_acc    = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int g = 0;
        while (!res_valid && g < 60) begin
            tick;
            g++;
        end
        if (g >= 60) chk({name, "_res_valid_wait"}, 0, 1);
    endtask

    typedef struct {
        int   nw;
        int   lastpos;
        logic truth;
        logic label;
        logic hang;
        int   hold;
        logic exp_res;
        logic exp_correct;
        logic exp_err_len;
        int   exp_sc;
        int   exp_cc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int t_acc;
        int s_rst, s_start, s_rv, g;
        logic [15:0] base;

        vecs[0] = '{11, 11, 1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b1, 1'b0, 1, 1};
        vecs[1] = '{11, 11, 1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b0, 2, 1};
        vecs[2] = '{ 4,  4, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b1, 2, 1};
        vecs[3] = '{11, 11, 1'b0, 1'b0, 1'b0,  2, 1'b1, 1'b1, 1'b0, 3, 2};
        vecs[4] = '{13, 13, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b1, 3, 2};
        vecs[5] = '{11, 11, 1'b0, 1'b1, 1'b0,  3, 1'b1, 1'b0, 1'b0, 4, 2};
        vecs[6] = '{11, 11, 1'b1, 1'b1, 1'b1,  0, 1'b0, 1'b0, 1'b0, 4, 2};
        vecs[7] = '{11, 11, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 5, 3};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_truth = 1'b0;
        clr_err = 1'b0; res_ready = 1'b0; tree_label = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_feat_bus", int'(feat_bus == '0), 1);
        chk("rst_tree_rst_n", tree_rst_n, 0);
        chk("rst_tree_start", tree_start, 0);
        chk("rst_res", {res_valid, res_label, res_correct}, 0);
        chk("rst_err", {err_len, err_timeout}, 0);
        chk("rst_counts", {sample_count, correct_count}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("tree_depth", tree_depth, 3);
        reset = 1'b1;
        tick;
        chk("tree_rst_n_release", tree_rst_n, 1);

        for (int i = 0; i < 8; i++) begin
            m_label_set(vecs[i].label);
            m_hang = vecs[i].hang;
            clr_err = 1'b1;
            tick;
            clr_err = 1'b0;
            chk($sformatf("v%0d_err_cleared", i), {err_len, err_timeout}, 0);
            s_rst = rst_low_tot; s_start = start_tot; s_rv = rv_tot;
            base = 16'((i + 1) * 256);
            send(vecs[i].nw, vecs[i].lastpos, vecs[i].truth, base, t_acc);
            if (vecs[i].exp_res) begin
                wait_result($sformatf("v%0d", i));
                chk($sformatf("v%0d_latency", i), cyc - t_acc, 8);
                chk($sformatf("v%0d_label", i), res_label, vecs[i].label);
                chk($sformatf("v%0d_correct", i), res_correct, vecs[i].exp_correct);
                chk($sformatf("v%0d_rst_low_cycles", i), rst_low_tot - s_rst, 1);
                chk($sformatf("v%0d_start_cycles", i), start_tot - s_start, 6);
                for (int f = 0; f < NF; f++)
                    chk($sformatf("v%0d_feat%0d", i, f), int'(feat_bus[f*FW +: FW]),
                        int'(base + 16'(NF - 1 - f)));
                for (int h = 0; h < vecs[i].hold; h++) begin
                    tick;
                    chk($sformatf("v%0d_hold%0d", i, h),
                        {res_valid, res_label, res_correct, in_ready},
                        {1'b1, vecs[i].label, vecs[i].exp_correct, 1'b0});
                end
                res_ready = 1'b1;
                tick;
                res_ready = 1'b0;
                chk($sformatf("v%0d_res_valid_drop", i), res_valid, 0);
            end else if (vecs[i].hang) begin
                g = 0;
                while (!tree_start && g < 10) begin tick; g++; end
                chk($sformatf("v%0d_start_rise", i), cyc - t_acc, 2);
                g = 0;
                while (tree_start && g < 60) begin tick; g++; end
                chk($sformatf("v%0d_timeout_drop", i), cyc - t_acc, 33);
                chk($sformatf("v%0d_err_timeout", i), err_timeout, 1);
                repeat (3) tick;
                chk($sformatf("v%0d_no_result", i), rv_tot - s_rv, 0);
                chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            end else begin
                repeat (12) tick;
                chk($sformatf("v%0d_err_len", i), err_len, 1);
                chk($sformatf("v%0d_no_clr", i), rst_low_tot - s_rst, 0);
                chk($sformatf("v%0d_no_start", i), start_tot - s_start, 0);
                chk($sformatf("v%0d_no_result", i), rv_tot - s_rv, 0);
                chk($sformatf("v%0d_in_ready", i), in_ready, 1);
                if (vecs[i].nw > NF)
                    chk($sformatf("v%0d_drop_feat0", i), int'(feat_bus[FW-1:0]),
                        int'(base + 16'(NF - 1)));
            end
            chk($sformatf("v%0d_sample_count", i), sample_count, vecs[i].exp_sc);
            chk($sformatf("v%0d_correct_count", i), correct_count, vecs[i].exp_cc);
        end

        // Error set coinciding with clr_err must leave the flag set.
        clr_err = 1'b1;
        send(4, 4, 1'b0, 16'h0F00, t_acc);
        chk("set_wins_err_len", err_len, 1);
        tick;
        chk("clr_err_after", err_len, 0);
        clr_err = 1'b0;

        // Reset during RUN.
        m_label_set(1'b1);
        m_hang = 1'b0;
        send(11, 11, 1'b1, 16'h0A00, t_acc);
        repeat (4) tick;
        chk("pre_reset_in_run", tree_start, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_outputs", {res_valid, tree_start, tree_rst_n, err_len, err_timeout}, 0);
        chk("async_rst_counts", {sample_count, correct_count}, 0);
        chk("async_rst_feat", int'(feat_bus == '0), 1);
        chk("async_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick;
        send(11, 11, 1'b1, 16'h0B00, t_acc);
        wait_result("post_reset");
        chk("post_reset_latency", cyc - t_acc, 8);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("post_reset_counts", {sample_count, correct_count}, {16'd1, 16'd1});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    task automatic m_label_set(input logic l);
        tree_label = l;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=%0d required=%0d", cyc, 0);
        $fatal(1, "bench timeout");
    end

endmodule
